contador_palabras: RTL

// - Word-counter responder at the output side of the transaction layer; it answers the bench's req/idx counter reads.
// - Counts words actually popped from each of the 4 output FIFOs (counters 0-3), plus a total counter 4.
// - Returns one counter on salida_contador with a valid_contador strobe, only while the layer FSM reports idle.

---
 rtl/contador_palabras.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/contador_palabras.sv
// -----------------------------------------------------------------------------
// contador_palabras
// Word counter at the output side of the transaction layer. Counts the words
// actually popped from each output FIFO (counters 0..N_FIFOS-1) plus a
// running total (counter N_FIFOS). It answers req/idx counter reads with a
// one-cycle latency, and only while the layer FSM reports idle.
//
// Ports:
//   clk             in   1        single clock, posedge
//   reset           in   1        synchronous, active-low; clears all state
//   init            in   1        synchronous clear of all counters
//   idle            in   1        layer FSM idle; reads are served only while 1
//   pop             in   N_FIFOS  pop strobes of output FIFOs
//   fifo_empty      in   N_FIFOS  empty flags, same cycle as pop
//   req             in   1        counter read request (level)
//   idx             in   3        counter select: 0..N_FIFOS-1 per FIFO,
//                                 N_FIFOS total, above that invalid
//   salida_contador out  WIDTH    selected counter value
//   valid_contador  out  1        salida_contador valid this cycle
//
// Configuration macro:
//   CONTADOR_SATURATE_EN  counters saturate at 2**WIDTH-1 instead of wrapping.
//                         The total saturates independently of the others.
// -----------------------------------------------------------------------------
module contador_palabras #(
    parameter int WIDTH   = 5,
    parameter int N_FIFOS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               init,
    input  logic               idle,
    input  logic [N_FIFOS-1:0] pop,
    input  logic [N_FIFOS-1:0] fifo_empty,
    input  logic               req,
    input  logic [2:0]         idx,
    output logic [WIDTH-1:0]   salida_contador,
    output logic               valid_contador
);

    typedef enum logic [1:0] {
        CUENTA   = 2'd0,
        LISTO    = 2'd1,
        RESPONDE = 2'd2
    } estado_t;

    estado_t            estado_r;
    estado_t            estado_nxt_s;

    logic [WIDTH-1:0]   cnt_r     [N_FIFOS+1];
    logic [WIDTH-1:0]   cnt_nxt_s [N_FIFOS+1];
    logic [N_FIFOS-1:0] pop_ef_s;
    logic [WIDTH-1:0]   salida_nxt_s;
    logic               valid_nxt_s;

    // Number of set bits, widened to WIDTH+1 so it can be added to a counter
    // without losing the carry.
    function automatic logic [WIDTH:0] popcount(input logic [N_FIFOS-1:0] v);
        logic [WIDTH:0] acc;
        acc = {(WIDTH+1){1'b0}};
        for (int i = 0; i < N_FIFOS; i++) begin
            acc = acc + {{WIDTH{1'b0}}, v[i]};
        end
        return acc;
    endfunction

    // Counter update: wraps modulo 2**WIDTH, or clamps at all-ones when
    // saturation is enabled.
    function automatic logic [WIDTH-1:0] incr(input logic [WIDTH-1:0] base,
                                              input logic [WIDTH:0]   delta);
        logic [WIDTH:0] sum;
        sum = {1'b0, base} + delta;
`ifdef CONTADOR_SATURATE_EN
        if (sum > {1'b0, {WIDTH{1'b1}}}) begin
            return {WIDTH{1'b1}};
        end else begin
            return sum[WIDTH-1:0];
        end
`else
        return sum[WIDTH-1:0];
`endif
    endfunction

    // A pop on an empty FIFO moves no word and is not counted.
    assign pop_ef_s = pop & ~fifo_empty;

    // Next counter values; init clears everything and drops this cycle's pops.
    always_comb begin
        for (int i = 0; i <= N_FIFOS; i++) begin
            cnt_nxt_s[i] = {WIDTH{1'b0}};
        end
        if (init) begin
            for (int i = 0; i <= N_FIFOS; i++) begin
                cnt_nxt_s[i] = {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < N_FIFOS; i++) begin
                cnt_nxt_s[i] = incr(cnt_r[i], {{WIDTH{1'b0}}, pop_ef_s[i]});
            end
            // The total is its own register fed by the popcount, so it stays
            // consistent with the per-FIFO counters without an adder tree.
            cnt_nxt_s[N_FIFOS] = incr(cnt_r[N_FIFOS], popcount(pop_ef_s));
        end
    end

    // Next state of the read FSM; idle low forces CUENTA from any state.
    always_comb begin
        estado_nxt_s = estado_r;
        if (!idle) begin
            estado_nxt_s = CUENTA;
        end else begin
            case (estado_r)
                CUENTA:   estado_nxt_s = LISTO;
                LISTO:    estado_nxt_s = req ? RESPONDE : LISTO;
                RESPONDE: estado_nxt_s = req ? RESPONDE : LISTO;
                default:  estado_nxt_s = CUENTA;
            endcase
        end
    end

    // Read response: sample the pre-increment counter whenever req and idle
    // are both high, so a request arriving with idle is answered next cycle.
    always_comb begin
        salida_nxt_s = salida_contador;
        valid_nxt_s  = 1'b0;
        if (idle && req) begin
            if (idx <= 3'(N_FIFOS)) begin
                salida_nxt_s = cnt_r[idx];
                valid_nxt_s  = 1'b1;
            end else begin
                salida_nxt_s = {WIDTH{1'b0}};
                valid_nxt_s  = 1'b0;
            end
        end else begin
            salida_nxt_s = salida_contador;
            valid_nxt_s  = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            estado_r <= CUENTA;
        end else begin
            estado_r <= estado_nxt_s;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i <= N_FIFOS; i++) begin
                cnt_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i <= N_FIFOS; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    // Registered read outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            salida_contador <= {WIDTH{1'b0}};
            valid_contador  <= 1'b0;
        end else begin
            salida_contador <= salida_nxt_s;
            valid_contador  <= valid_nxt_s;
        end
    end

endmodule
